// File: rtl/mii_rx_framer_if.sv
// MII receive pins plus the framed byte/status stream of mii_rx_framer.
// master = PHY/consumer side, slave = the framer itself.
interface mii_rx_framer_if #(
    parameter int LEN_W = 11
) ();
    logic             eth_rx_dv;
    logic [3:0]       eth_rxd;
    logic             eth_rxerr;
    logic [7:0]       byte_data;
    logic             byte_valid;
    logic             frame_start;
    logic             frame_end;
    logic [LEN_W-1:0] frame_len;
    logic [3:0]       frame_status;
    logic [15:0]      frame_count;

    modport master (
        output eth_rx_dv, eth_rxd, eth_rxerr,
        input  byte_data, byte_valid, frame_start, frame_end,
               frame_len, frame_status, frame_count
    );

    modport slave (
        input  eth_rx_dv, eth_rxd, eth_rxerr,
        output byte_data, byte_valid, frame_start, frame_end,
               frame_len, frame_status, frame_count
    );
endinterface

// File: rtl/mii_rx_framer.sv
// MII RX framer: strips preamble/SFD, packs low-nibble-first bytes, reports length/status.
// Optional macro FCS_CHECK_EN adds a CRC-32 residue check reported in frame_status[3].
module mii_rx_framer #(
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11,
    parameter int MIN_PRE = 2
) (
    input  logic            eth_rx_clk,
    input  logic            rst,
    mii_rx_framer_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PRE  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_DROP = 3'd3;
    localparam logic [2:0] ST_WAIT = 3'd4;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
    localparam logic [7:0]       PRE_MIN = 8'(MIN_PRE);

    logic [2:0]       r_state;
    logic [7:0]       r_pre_cnt;
    logic             r_phase;
    logic [3:0]       r_low;
    logic [LEN_W-1:0] r_len;
    logic             r_err;
    logic [7:0]       r_byte_data;
    logic             r_byte_valid;
    logic             r_frame_start;
    logic             r_frame_end;
    logic [LEN_W-1:0] r_frame_len;
    logic [3:0]       r_frame_status;
    logic [15:0]      r_frame_count;

    logic       w_dv;
    logic [3:0] w_rxd;
    logic       w_sfd;
    logic       w_emit;
    logic [7:0] w_byte;
    logic       w_fcs_bad;

    assign w_dv   = bus.eth_rx_dv;
    assign w_rxd  = bus.eth_rxd;
    assign w_byte = {w_rxd, r_low};
    assign w_sfd  = (r_state == ST_PRE) && w_dv && !bus.eth_rxerr &&
                    (w_rxd == 4'hD) && (r_pre_cnt >= PRE_MIN);
    assign w_emit = (r_state == ST_DATA) && w_dv && r_phase && (r_len != LEN_MAX);

`ifdef FCS_CHECK_EN
    logic [31:0] r_crc;
    logic [31:0] w_crc_next;
    logic [31:0] w_crc_rev;

    // Reflected CRC-32, one byte per emitted strobe.
    always_comb begin
        w_crc_next = r_crc ^ {24'h0, w_byte};
        for (int i = 0; i < 8; i++)
            w_crc_next = w_crc_next[0] ? ((w_crc_next >> 1) ^ 32'hEDB88320) : (w_crc_next >> 1);
    end

    always_comb begin
        w_crc_rev = '0;
        for (int i = 0; i < 32; i++) w_crc_rev[i] = r_crc[31-i];
    end

    // The magic residue is stated MSB-first, so compare against the bit-reversed register.
    assign w_fcs_bad = (w_crc_rev != 32'hC704DD7B) || (r_len < LEN_W'(4));

    always_ff @(posedge eth_rx_clk) begin
        if (rst)         r_crc <= '0;
        else if (w_sfd)  r_crc <= 32'hFFFFFFFF;
        else if (w_emit) r_crc <= w_crc_next;
    end
`else
    assign w_fcs_bad = 1'b0;
`endif

    always_ff @(posedge eth_rx_clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_pre_cnt      <= '0;
            r_phase        <= 1'b0;
            r_low          <= '0;
            r_len          <= '0;
            r_err          <= 1'b0;
            r_byte_data    <= '0;
            r_byte_valid   <= 1'b0;
            r_frame_start  <= 1'b0;
            r_frame_end    <= 1'b0;
            r_frame_len    <= '0;
            r_frame_status <= '0;
            r_frame_count  <= '0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_dv) begin
                        if (w_rxd == 4'h5) begin
                            r_state   <= ST_PRE;
                            r_pre_cnt <= 8'd1;
                        end else begin
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_PRE: begin
                    if (!w_dv)
                        r_state <= ST_IDLE;
                    else if (w_sfd) begin
                        r_state <= ST_DATA;
                        r_phase <= 1'b0;
                        r_len   <= '0;
                        r_err   <= 1'b0;
                    end else if (!bus.eth_rxerr && w_rxd == 4'h5) begin
                        if (r_pre_cnt != 8'hFF) r_pre_cnt <= r_pre_cnt + 8'd1;
                    end else
                        r_state <= ST_WAIT;
                end
                ST_DATA: begin
                    if (!w_dv) begin
                        r_state        <= ST_IDLE;
                        r_frame_end    <= 1'b1;
                        r_frame_len    <= r_len;
                        r_frame_status <= {w_fcs_bad, 1'b0, r_phase, r_err};
                        r_frame_count  <= r_frame_count + 16'd1;
                    end else begin
                        if (bus.eth_rxerr) r_err <= 1'b1;
                        if (!r_phase) begin
                            r_low   <= w_rxd;
                            r_phase <= 1'b1;
                        end else begin
                            r_phase <= 1'b0;
                            if (w_emit) begin
                                r_byte_data   <= w_byte;
                                r_byte_valid  <= 1'b1;
                                r_frame_start <= (r_len == '0);
                                r_len         <= r_len + 1'b1;
                            end else begin
                                r_state <= ST_DROP;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (!w_dv) begin
                        r_state        <= ST_IDLE;
                        r_frame_end    <= 1'b1;
                        r_frame_len    <= r_len;
                        r_frame_status <= {w_fcs_bad, 1'b1, 1'b0, r_err};
                        r_frame_count  <= r_frame_count + 16'd1;
                    end
                end
                ST_WAIT: begin
                    if (!w_dv) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.byte_data    = r_byte_data;
    assign bus.byte_valid   = r_byte_valid;
    assign bus.frame_start  = r_frame_start;
    assign bus.frame_end    = r_frame_end;
    assign bus.frame_len    = r_frame_len;
    assign bus.frame_status = r_frame_status;
    assign bus.frame_count  = r_frame_count;
endmodule

// File: doc/mii_rx_framer.md
Name: mii_rx_framer

Overview:
Receive-side MII framer placed directly downstream of the PHY MII RX pins and upstream of the display/consumer logic. It strips the preamble and SFD, assembles low-nibble-first nibbles into bytes, and emits a byte stream with start/end-of-frame markers. It also reports per-frame length and error status and keeps a running frame counter.

Parameters:
MAX_LEN, 1518, maximum accepted frame length in bytes (DA through FCS); the byte that would make the frame longer is not emitted.
LEN_W, 11, width of frame_len; must hold MAX_LEN.
MIN_PRE, 2, minimum number of 0x5 preamble nibbles required before the SFD nibble 0xD.

Ports:
eth_rx_clk  in  1  MII receive clock, 25 MHz; the only clock.
rst  in  1  synchronous, active-high reset.
eth_rx_dv  in  1  MII receive data valid.
eth_rxd  in  4  MII receive nibble.
eth_rxerr  in  1  MII receive error.
byte_data  out  8  assembled byte {high nibble, low nibble}.
byte_valid  out  1  one-cycle strobe; byte_data valid.
frame_start  out  1  high together with byte_valid on the first byte of a frame.
frame_end  out  1  one-cycle pulse after the frame terminates; frame_len and frame_status are valid in the same cycle.
frame_len  out  LEN_W  bytes emitted for the frame.
frame_status  out  4  bit0 rxerr seen, bit1 odd nibble count, bit2 overlength, bit3 FCS bad (macro only).
frame_count  out  16  count of frame_end pulses; wraps at 0xFFFF -> 0.

Behaviour:
- Clock and reset: already decided, one clock (eth_rx_clk); reset is synchronous and active-high (rst).
- Reset values: all outputs 0, state IDLE, all internal counters 0. Reset asserted mid-frame aborts the frame with no frame_end pulse.
- All inputs are sampled on the rising edge of eth_rx_clk. All outputs are registered.
- States: IDLE, PREAMBLE, DATA, DROP, WAIT_IDLE.
- IDLE:
  - dv=1 and rxd=0x5 -> PREAMBLE, pre_cnt=1.
  - dv=1 and any other nibble -> WAIT_IDLE. This blocks joining a frame mid-stream, including when dv is already high at reset release.
- PREAMBLE:
  - rxd=0x5 -> pre_cnt++ (saturating).
  - rxd=0xD and pre_cnt>=MIN_PRE -> DATA, nibble phase=0, len=0, status=0.
  - rxd=0xD with pre_cnt<MIN_PRE, any other nibble, or rxerr -> WAIT_IDLE.
  - dv falls -> IDLE.
  - No frame outputs are produced in any of these cases.
- DATA, dv=1:
  - phase 0: latch low nibble.
  - phase 1: byte_data={rxd, low}, byte_valid=1 on the next cycle. Latency is one cycle after the high-nibble edge.
  - frame_start=1 on the first byte only. len increments per byte.
  - eth_rxerr=1 on any DATA cycle sets status bit0; bytes keep flowing.
- DATA, overlength: if a byte completes while len==MAX_LEN, that byte is not emitted, bit2 is set, and the block goes to DROP.
- DATA, dv falls (dv=0 sampled):
  - go to IDLE.
  - pulse frame_end on the next cycle.
  - frame_len=len.
  - bit1 set if phase==1 (dangling nibble, discarded).
  - frame_count++.
- DROP: ignore nibbles; on dv=0 -> IDLE with the frame_end pulse as above (frame_len=MAX_LEN, bit2 set).
- WAIT_IDLE: ignore everything until dv=0 -> IDLE; no outputs.
- A frame ending with 0 complete bytes (SFD then dv drop) still pulses frame_end with frame_len=0 and frame_start never asserted.
- frame_len and frame_status hold their values until the next frame_end.
- Back-to-back frames:
  - dv may rise again on the cycle right after the dv=0 sample; the new frame's preamble is tracked normally.
  - frame_end of the old frame may coincide with PREAMBLE of the new one.

Optional Feature:
FCS_CHECK_EN:
- Defined: a CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) is updated per emitted byte, including the FCS bytes.
  - At frame_end, bit3=1 if the residue != 0xC704DD7B, or if len<4.
  - CRC update is on the byte_valid path; no added latency.
- Undefined: no CRC logic; bit3 is constant 0.

Test Plan:
- 15x nibble 0x5, 0xD, then 64 bytes 0x00..0x3F (low nibble first), dv drop -> 64 byte_valid strobes with data 0x00..0x3F, frame_start on byte 0x00, frame_end with frame_len=64, status=0, frame_count=1.
- Preamble 0x5,0xD (pre_cnt=1, MIN_PRE=2) -> no byte_valid, no frame_end, frame_count unchanged; a following valid frame is received normally.
- Valid frame with eth_rxerr pulsed during byte 10, and a 65th odd nibble -> 64 bytes emitted, frame_end status=4'b0011.
- 1600-byte frame -> exactly 1518 byte_valid strobes, frame_len=1518, status bit2=1.
- Reset released with dv already high mid-frame -> no outputs until dv low; next frame is received with frame_count=1. Also: two frames separated by a single dv=0 cycle -> two frame_end pulses, frame_count=2.
- FCS_CHECK_EN: 60-byte payload plus correct FCS -> bit3=0; the same frame with one payload bit flipped -> bit3=1.
